// File: rtl/operand_fetch_pkg.sv
// Shared register-index definitions for the operand-fetch stage and its scoreboard.
package operand_fetch_pkg;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREG      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  // x0 is hardwired, so it never produces or consumes a real dependency.
  function automatic logic is_real(input reg_idx_t idx);
    return idx != REG_ZERO;
  endfunction
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard of in-flight destinations; flags RAW/WAW hazards for the
// instruction currently presented at decode.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int unsigned NUM_REGS = NREG
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr_valid,
  input  reg_idx_t clr_sel,
  input  logic     fclr_valid,
  input  reg_idx_t fclr_sel,
  input  logic     set_valid,
  input  reg_idx_t set_sel,
  input  logic     rs1_use,
  input  reg_idx_t rs1_sel,
  input  logic     rs2_use,
  input  reg_idx_t rs2_sel,
  input  reg_idx_t rd_sel,
  output logic     hazard
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] busy_eff, clr_mask, fclr_mask, set_mask;

  always_comb begin
    clr_mask  = (clr_valid && is_real(clr_sel))   ? (NUM_REGS'(1) << clr_sel)  : '0;
    fclr_mask = (fclr_valid && is_real(fclr_sel)) ? (NUM_REGS'(1) << fclr_sel) : '0;
    set_mask  = (set_valid && is_real(set_sel))   ? (NUM_REGS'(1) << set_sel)  : '0;

    // A same-cycle retire is bypassed by the register file, so it no longer blocks.
    busy_eff = busy_q & ~clr_mask;
    // busy_q[0] is never set, so x0 operands fall out of these terms naturally.
    hazard = (rs1_use && busy_eff[rs1_sel]) ||
             (rs2_use && busy_eff[rs2_sel]) ||
             busy_eff[rd_sel];

    busy_d    = (busy_eff & ~fclr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch/issue stage: reads the register file, stalls on scoreboard
// hazards and holds the issued instruction in a single output register.
module operand_fetch
  import operand_fetch_pkg::reg_idx_t;
  import operand_fetch_pkg::is_real;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [4:0]       in_rs1_sel,
  input  logic [4:0]       in_rs2_sel,
  input  logic [4:0]       in_rd_sel,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  output logic [4:0]       rf_rs1_sel,
  output logic [4:0]       rf_rs2_sel,
  input  logic [WIDTH-1:0] rf_rs1,
  input  logic [WIDTH-1:0] rf_rs2,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_rs1,
  output logic [WIDTH-1:0] out_rs2,
  output logic [4:0]       out_rd_sel,
  output logic [31:0]      stall_count
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_instr_q, out_instr_d;
  logic [WIDTH-1:0] out_rs1_q, out_rs1_d;
  logic [WIDTH-1:0] out_rs2_q, out_rs2_d;
  reg_idx_t         out_rd_sel_q, out_rd_sel_d;
  logic [31:0]      stall_count_q, stall_count_d;
  logic             hazard, space, issue;

  operand_fetch_scoreboard #(
    .NUM_REGS(NREG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .clr_valid (wb_valid),
    .clr_sel   (wb_rd_sel),
    .fclr_valid(flush && out_valid_q),
    .fclr_sel  (out_rd_sel_q),
    .set_valid (issue && is_real(in_rd_sel)),
    .set_sel   (in_rd_sel),
    .rs1_use   (in_use_rs1),
    .rs1_sel   (in_rs1_sel),
    .rs2_use   (in_use_rs2),
    .rs2_sel   (in_rs2_sel),
    .rd_sel    (in_rd_sel),
    .hazard    (hazard)
  );

  always_comb begin
    rf_rs1_sel = in_rs1_sel;
    rf_rs2_sel = in_rs2_sel;
    space      = !out_valid_q || out_ready;
    in_ready   = !halt && !flush && !hazard && space;
    issue      = in_valid && in_ready;

    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_rs1_d    = out_rs1_q;
    out_rs2_d    = out_rs2_q;
    out_rd_sel_d = out_rd_sel_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_instr_d  = in_instr;
      out_rs1_d    = rf_rs1;
      out_rs2_d    = rf_rs2;
      out_rd_sel_d = in_rd_sel;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end

    stall_count_d = stall_count_q + 32'(in_valid && !in_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= '0;
      out_instr_q   <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_rd_sel_q  <= '0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_rd_sel_q  <= out_rd_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_rd_sel  = out_rd_sel_q;
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/handshake scenarios plus a random run
// checked against a pending-destination list model.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset, halt, flush, in_valid, in_ready;
  logic [31:0] in_instr, rf_rs1, rf_rs2, out_instr, out_rs1, out_rs2, stall_count;
  logic [4:0]  in_rs1_sel, in_rs2_sel, in_rd_sel, rf_rs1_sel, rf_rs2_sel, wb_rd_sel, out_rd_sel;
  logic        in_use_rs1, in_use_rs2, wb_valid, out_valid, out_ready;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  operand_fetch #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_sel(in_rs1_sel), .in_rs2_sel(in_rs2_sel), .in_rd_sel(in_rd_sel),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .rf_rs1_sel(rf_rs1_sel), .rf_rs2_sel(rf_rs2_sel), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .wb_valid(wb_valid), .wb_rd_sel(wb_rd_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_sel(out_rd_sel),
    .stall_count(stall_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    halt = 0; flush = 0; in_valid = 0; out_ready = 1; wb_valid = 0; wb_rd_sel = 0;
    in_rs1_sel = 0; in_rs2_sel = 0; in_rd_sel = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_instr = 0; rf_rs1 = 0; rf_rs2 = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1; in_instr = 32'hFFFF_FFFF; rf_rs1 = 32'h55; in_rd_sel = 5'd3;
    reset = 1;
    step();
    reset = 0; in_valid = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr got=%0h exp=0", out_instr); end
    tests++; if (out_rs1 !== 32'h0 || out_rs2 !== 32'h0) begin fails++; $display("FAIL reset_out_rs got=%0h/%0h exp=0/0", out_rs1, out_rs2); end
    tests++; if (out_rd_sel !== 5'd0) begin fails++; $display("FAIL reset_out_rd got=%0h exp=0", out_rd_sel); end
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall got=%0h exp=0", stall_count); end
    in_rs1_sel = 5'd17; in_rs2_sel = 5'd30;
    #1;
    tests++; if (rf_rs1_sel !== 5'd17 || rf_rs2_sel !== 5'd30) begin fails++; $display("FAIL rf_sel_copy got=%0d/%0d exp=17/30", rf_rs1_sel, rf_rs2_sel); end
  endtask

  task automatic test_basic_issue();
    do_reset();
    in_valid = 1; in_instr = 32'hCAFE_0001; in_rs1_sel = 1; in_rs2_sel = 2; in_rd_sel = 3;
    in_use_rs1 = 1; in_use_rs2 = 1; rf_rs1 = 32'h11; rf_rs2 = 32'h22;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
    tests++; if (out_rs1 !== 32'h11 || out_rs2 !== 32'h22) begin fails++; $display("FAIL basic_operands got=%0h/%0h exp=11/22", out_rs1, out_rs2); end
    tests++; if (out_rd_sel !== 5'd3 || out_instr !== 32'hCAFE_0001) begin fails++; $display("FAIL basic_rd_instr got=%0d/%0h exp=3/cafe0001", out_rd_sel, out_instr); end
    in_rs1_sel = 3; in_rs2_sel = 0; in_use_rs2 = 0; in_rd_sel = 0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_busy3 got=%0h exp=0", in_ready); end
    wb_valid = 1; wb_rd_sel = 3;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_retire3 got=%0h exp=1", in_ready); end
    step();
    idle();
  endtask

  task automatic test_raw();
    do_reset();
    in_valid = 1; in_rd_sel = 5;
    step();
    in_rd_sel = 0; in_rs1_sel = 5; in_use_rs1 = 1; rf_rs1 = 32'h77;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall got=%0h exp=0", in_ready); end
    repeat (3) step();
    tests++; if (stall_count !== 32'd3) begin fails++; $display("FAIL raw_stall_count got=%0d exp=3", stall_count); end
    wb_valid = 1; wb_rd_sel = 5; rf_rs1 = 32'hAB;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_bypass_ready got=%0h exp=1", in_ready); end
    step();
    idle();
    tests++; if (out_rs1 !== 32'hAB || out_valid !== 1'b1) begin fails++; $display("FAIL raw_bypass_data got=%0h/%0h exp=ab/1", out_rs1, out_valid); end
    tests++; if (stall_count !== 32'd3) begin fails++; $display("FAIL raw_stall_hold got=%0d exp=3", stall_count); end
  endtask

  task automatic test_waw();
    do_reset();
    in_valid = 1; in_rd_sel = 7; in_instr = 32'h1;
    step();
    in_instr = 32'h2;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL waw_stall got=%0h exp=0", in_ready); end
    step();
    wb_valid = 1; wb_rd_sel = 7;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL waw_release got=%0h exp=1", in_ready); end
    step();
    idle();
    tests++; if (out_instr !== 32'h2 || out_rd_sel !== 5'd7) begin fails++; $display("FAIL waw_issue got=%0h/%0d exp=2/7", out_instr, out_rd_sel); end
    in_rs1_sel = 7; in_use_rs1 = 1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL waw_reset_busy got=%0h exp=0", in_ready); end
    tests++; if (stall_count !== 32'd1) begin fails++; $display("FAIL waw_stall_count got=%0d exp=1", stall_count); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 0; in_valid = 1; in_instr = 32'hA; rf_rs1 = 32'h1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got=%0h exp=1", in_ready); end
    step();
    in_instr = 32'hB; rf_rs1 = 32'h2;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_blocked got=%0h exp=0", in_ready); end
    repeat (2) step();
    tests++; if (out_valid !== 1'b1 || out_rs1 !== 32'h1 || out_instr !== 32'hA) begin fails++; $display("FAIL bp_hold got=%0h/%0h/%0h exp=1/1/a", out_valid, out_rs1, out_instr); end
    tests++; if (stall_count !== 32'd2) begin fails++; $display("FAIL bp_stall_count got=%0d exp=2", stall_count); end
    out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got=%0h exp=1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1 || out_rs1 !== 32'h2 || out_instr !== 32'hB) begin fails++; $display("FAIL bp_no_bubble got=%0h/%0h/%0h exp=1/2/b", out_valid, out_rs1, out_instr); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1; in_rd_sel = 9;
    step();
    in_rd_sel = 0; in_rs1_sel = 9; in_use_rs1 = 1; rf_rs1 = 32'h99; out_ready = 0; flush = 1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
    step();
    flush = 0; out_ready = 1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_clears_busy got=%0h exp=1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1 || out_rs1 !== 32'h99) begin fails++; $display("FAIL flush_reader got=%0h/%0h exp=1/99", out_valid, out_rs1); end
    tests++; if (stall_count !== 32'd1) begin fails++; $display("FAIL flush_stall_count got=%0d exp=1", stall_count); end
    idle();
  endtask

  task automatic test_x0_halt();
    do_reset();
    in_valid = 1; in_rd_sel = 0;
    step();
    in_use_rs1 = 1; in_use_rs2 = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_no_stall got=%0h exp=1", in_ready); end
    step();
    in_use_rs1 = 0; in_use_rs2 = 0; in_rd_sel = 4; in_instr = 32'h44;
    step();
    in_rd_sel = 0; in_rs1_sel = 4; in_use_rs1 = 1; halt = 1; out_ready = 0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL halt_ready got=%0h exp=0", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_rd_sel !== 5'd4) begin fails++; $display("FAIL halt_hold got=%0h/%0d exp=1/4", out_valid, out_rd_sel); end
    out_ready = 1; wb_valid = 1; wb_rd_sel = 4;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL halt_no_issue got=%0h exp=0", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL halt_drain got=%0h exp=0", out_valid); end
    tests++; if (stall_count !== 32'd2) begin fails++; $display("FAIL halt_stall_count got=%0d exp=2", stall_count); end
    halt = 0; wb_valid = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL halt_clr_applied got=%0h exp=1", in_ready); end
    idle();
  endtask

  task automatic test_reset_midstall();
    do_reset();
    in_valid = 1; in_rd_sel = 6; rf_rs1 = 32'h66;
    step();
    in_rd_sel = 0; in_rs1_sel = 6; in_use_rs1 = 1;
    repeat (2) step();
    reset = 1;
    step();
    reset = 0; in_valid = 0;
    tests++; if (out_valid !== 1'b0 || out_rs1 !== 32'h0) begin fails++; $display("FAIL midreset_out got=%0h/%0h exp=0/0", out_valid, out_rs1); end
    tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL midreset_stall got=%0d exp=0", stall_count); end
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_busy got=%0h exp=1", in_ready); end
    idle();
  endtask

  // True when r names a producer still outstanding after this cycle's retire.
  function automatic bit pending(input int qq[$], input int r);
    if (r == 0) return 0;
    if (wb_valid && int'(wb_rd_sel) == r) return 0;
    foreach (qq[i]) if (qq[i] == r) return 1;
    return 0;
  endfunction

  task automatic test_random();
    int          q[$];
    bit          ev, hz, rdy;
    logic [31:0] ei, e1, e2, es;
    int          erd;
    do_reset();
    ev = 0; ei = 0; e1 = 0; e2 = 0; erd = 0; es = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      halt       = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_rs1_sel = 5'($urandom_range(0, 7));
      in_rs2_sel = 5'($urandom_range(0, 7));
      in_rd_sel  = 5'($urandom_range(0, 7));
      in_use_rs1 = 1'($urandom_range(0, 1));
      in_use_rs2 = 1'($urandom_range(0, 1));
      in_instr   = $urandom; rf_rs1 = $urandom; rf_rs2 = $urandom;
      wb_valid   = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) wb_rd_sel = 5'(q[$urandom_range(0, q.size() - 1)]);
      else wb_rd_sel = 5'($urandom_range(0, 7));
      #1;
      hz  = (in_use_rs1 && pending(q, in_rs1_sel)) || (in_use_rs2 && pending(q, in_rs2_sel)) || pending(q, in_rd_sel);
      rdy = !halt && !flush && !hz && (!ev || out_ready);
      tests++; if (in_ready !== rdy) begin fails++; $display("FAIL rnd_in_ready cyc=%0d got=%0h exp=%0h", c, in_ready, rdy); end
      tests++; if (rf_rs1_sel !== in_rs1_sel || rf_rs2_sel !== in_rs2_sel) begin fails++; $display("FAIL rnd_rf_sel cyc=%0d got=%0d/%0d exp=%0d/%0d", c, rf_rs1_sel, rf_rs2_sel, in_rs1_sel, in_rs2_sel); end
      if (in_valid && !rdy) es++;
      if (wb_valid) for (int i = q.size() - 1; i >= 0; i--) if (q[i] == int'(wb_rd_sel)) q.delete(i);
      if (flush && ev) for (int i = q.size() - 1; i >= 0; i--) if (q[i] == erd) q.delete(i);
      if (in_valid && rdy) begin
        if (in_rd_sel != 0) q.push_back(int'(in_rd_sel));
        ev = 1; ei = in_instr; e1 = rf_rs1; e2 = rf_rs2; erd = int'(in_rd_sel);
      end else if (flush || (ev && out_ready)) begin
        ev = 0;
      end
      step();
      tests++; if (out_valid !== ev) begin fails++; $display("FAIL rnd_out_valid cyc=%0d got=%0h exp=%0h", c, out_valid, ev); end
      tests++; if (out_instr !== ei || out_rs1 !== e1 || out_rs2 !== e2 || out_rd_sel !== 5'(erd)) begin
        fails++; $display("FAIL rnd_out_data cyc=%0d got=%0h/%0h/%0h/%0d exp=%0h/%0h/%0h/%0d", c, out_instr, out_rs1, out_rs2, out_rd_sel, ei, e1, e2, erd);
      end
      tests++; if (stall_count !== es) begin fails++; $display("FAIL rnd_stall_count cyc=%0d got=%0d exp=%0d", c, stall_count, es); end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_basic_issue();
    test_raw();
    test_waw();
    test_back_to_back();
    test_flush();
    test_x0_halt();
    test_reset_midstall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
